// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 field widths, constants and divider FSM encoding
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam int QBITS_DEF = 26;
  localparam logic [31:0] QNAN_DEF = 32'h7FC0_0000;
  localparam logic [31:0] INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational FP32 field split and operand classification
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W:0]   man24,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan,
  output logic             is_sub
);
  logic exp_max;
  logic exp_min;
  logic man_nz;

  assign sign    = word[31];
  assign exp     = word[MAN_W +: EXP_W];
  assign man_nz  = |word[MAN_W-1:0];
  assign exp_max = &exp;
  assign exp_min = ~|exp;
  // Hidden bit is zero only for zero/subnormal encodings.
  assign man24   = {~exp_min, word[MAN_W-1:0]};
  assign is_zero = exp_min & ~man_nz;
  assign is_sub  = exp_min & man_nz;
  assign is_inf  = exp_max & ~man_nz;
  assign is_nan  = exp_max & man_nz;
endmodule

// File: rtl/fp32_divider_seq.sv
// rtl/fp32_divider_seq.sv - sequential FP32 divider, restoring mantissa division, one bit per cycle
module fp32_divider_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] QNAN  = QNAN_DEF,
  parameter int          QBITS = QBITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        dz,
  output logic        ovf,
  output logic        unf
);
  state_t state;

  logic        a_sign, a_zero_raw, a_inf, a_nan, a_sub;
  logic        b_sign, b_zero_raw, b_inf, b_nan, b_sub;
  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_man, b_man;

  fp32_classify u_cls_a (.word(in_1), .sign(a_sign), .exp(a_exp), .man24(a_man),
                         .is_zero(a_zero_raw), .is_inf(a_inf), .is_nan(a_nan), .is_sub(a_sub));
  fp32_classify u_cls_b (.word(in_2), .sign(b_sign), .exp(b_exp), .man24(b_man),
                         .is_zero(b_zero_raw), .is_inf(b_inf), .is_nan(b_nan), .is_sub(b_sub));

  logic        res_sign, a_zero, b_zero, lt;
  logic [9:0]  e0;
  logic        sp_hit, sp_dz;
  logic [31:0] sp_out;

  assign res_sign = a_sign ^ b_sign;
  assign a_zero   = a_zero_raw | a_sub;
  assign b_zero   = b_zero_raw | b_sub;
  assign lt       = a_man < b_man;
  // Pre-normalising the dividend keeps the quotient in [1,2).
  assign e0       = {2'b00, a_exp} - {2'b00, b_exp} + 10'(BIAS) - {9'd0, lt};

  always_comb begin
    sp_hit = 1'b1;
    sp_dz  = 1'b0;
    sp_out = 32'd0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_out = QNAN;
    end else if (a_inf) begin
      sp_out = {res_sign, INF[30:0]};
    end else if (b_zero) begin
      sp_out = {res_sign, INF[30:0]};
      sp_dz  = 1'b1;
    end else if (a_zero | b_inf) begin
      sp_out = {res_sign, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic               q_sign;
  logic signed [9:0]  q_exp;
  logic [24:0]        rem;
  logic [23:0]        divisor;
  logic [QBITS-2:0]   q;
  logic [4:0]         cnt;

  logic        ge;
  logic [24:0] rem_keep;
  assign ge       = rem >= {1'b0, divisor};
  assign rem_keep = ge ? (rem - {1'b0, divisor}) : rem;

  logic               rup, carry;
  logic [23:0]        frac_r;
  logic signed [9:0]  exp_r;
  assign rup    = q[1] & (q[0] | (|rem) | q[2]);
  assign frac_r = {1'b0, q[QBITS-2:2]} + {23'd0, rup};
  assign carry  = frac_r[23];
  assign exp_r  = q_exp + {9'd0, carry};

  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= 32'd0;
      out_valid <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      q_sign    <= 1'b0;
      q_exp     <= '0;
      rem       <= '0;
      divisor   <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dz      <= 1'b0;
          ovf     <= 1'b0;
          unf     <= 1'b0;
          q_sign  <= res_sign;
          q_exp   <= e0;
          rem     <= lt ? {a_man, 1'b0} : {1'b0, a_man};
          divisor <= b_man;
          q       <= '0;
          cnt     <= '0;
          if (sp_hit) begin
            out   <= sp_out;
            dz    <= sp_dz;
            state <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= {q[QBITS-3:0], ge};
          rem <= rem_keep << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1)) state <= ROUND;
        end
        ROUND: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (exp_r >= 10'sd255) begin
            out <= {q_sign, INF[30:0]};
            ovf <= 1'b1;
          end else if (exp_r <= 10'sd0) begin
            out <= {q_sign, 31'd0};
            unf <= 1'b1;
          end else begin
            out <= {q_sign, exp_r[7:0], frac_r[22:0]};
          end
        end
        DONE: begin
          // Special results arrive here with out_valid still low; raise it one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_divider_seq.sv
// tb/tb_fp32_divider_seq.sv - self-checking bench for fp32_divider_seq
module tb_fp32_divider_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_1, in_2;
  logic        in_ready, out_valid, dz, ovf, unf;
  logic [31:0] out;

  int total = 0;
  int bad = 0;

  fp32_divider_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .dz(dz), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        dz;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    logic [63:0] bits;
    bits = {1'b0, 11'(32'(x[30:23]) + 32'd896), x[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  // Reference: special-case rules, else exact double division rounded to FP32 with RNE.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic d, output logic v,
                                output logic u, output int lat);
    logic        s, an, bn, ai, bi, az, bz;
    logic [63:0] bits;
    logic [24:0] m;
    logic [28:0] rest;
    int          e;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = a[30:23] == 8'h00;
    bz = b[30:23] == 8'h00;
    d = 1'b0; v = 1'b0; u = 1'b0; lat = 1;
    if (an || bn || (az && bz) || (ai && bi)) o = 32'h7FC0_0000;
    else if (ai) o = {s, 31'h7F80_0000};
    else if (bz) begin o = {s, 31'h7F80_0000}; d = 1'b1; end
    else if (az || bi) o = {s, 31'd0};
    else begin
      lat  = 27;
      bits = $realtobits(to_real(a) / to_real(b));
      e    = int'(bits[62:52]) - 896;
      m    = {2'b01, bits[51:29]};
      rest = bits[28:0];
      if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0])) m = m + 25'd1;
      if (m[24]) begin m = m >> 1; e++; end
      if (e >= 255) begin o = {s, 31'h7F80_0000}; v = 1'b1; end
      else if (e <= 0) begin o = {s, 31'd0}; u = 1'b1; end
      else o = {s, e[7:0], m[22:0]};
    end
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 60) begin @(posedge clk); #1; guard++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] o,
                        output logic d, output logic v, output logic u, output int lat);
    wait_ready();
    in_1 = a; in_2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_1 = $urandom; in_2 = $urandom;
    wait_valid(lat);
    o = out; d = dz; v = ovf; u = unf;
    @(posedge clk); #1;
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o, eo;
    logic d, v, u, ed, ev, eu;
    int lat, elat;
    model(a, b, eo, ed, ev, eu, elat);
    run_op(a, b, o, d, v, u, lat);
    check($sformatf("%s_out(%h/%h)", tag, a, b), o, eo);
    check($sformatf("%s_flags(%h/%h)", tag, a, b), {29'd0, d, v, u}, {29'd0, ed, ev, eu});
    check($sformatf("%s_lat(%h/%h)", tag, a, b), 32'(lat), 32'(elat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o, a, b;
    logic d, v, u;
    int lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_1 = 32'd0; in_2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_flags", {29'd0, dz, ovf, unf}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 0, 27};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0, 27};
    vecs[2]  = '{32'hBF800000, 32'h40000000, 32'hBF000000, 0, 0, 0, 27};
    vecs[3]  = '{32'hBF800000, 32'hBF800000, 32'h3F800000, 0, 0, 0, 27};
    vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0, 1};
    vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 1};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 0, 1};
    vecs[7]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 0, 1, 0, 27};
    vecs[8]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 0, 0, 1, 27};
    vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 0, 1};
    vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0, 0, 1};
    vecs[11] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 0, 0, 0, 1};
    vecs[12] = '{32'h40000000, 32'h7F800000, 32'h00000000, 0, 0, 0, 1};
    vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 0, 0, 0, 1};

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, o, d, v, u, lat);
      check($sformatf("vec%0d_out", i), o, vecs[i].o);
      check($sformatf("vec%0d_flags", i), {29'd0, d, v, u},
            {29'd0, vecs[i].dz, vecs[i].ovf, vecs[i].unf});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        2: begin
          a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        end
        default: begin
          a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
          case ($urandom_range(0, 3))
            0: b = {1'($urandom), 31'd0};
            1: b = {1'($urandom), 8'd0, 23'($urandom_range(1, 1000))};
            2: b = {1'($urandom), 31'h7F800000};
            default: b = 32'h7FC00000 | 32'($urandom_range(0, 255));
          endcase
        end
      endcase
      run_and_check($sformatf("rnd%0d", i), a, b);
    end

    // Back-pressure: result must hold while new operands are offered and ignored.
    out_ready = 1'b0;
    wait_ready();
    in_1 = 32'h3F800000; in_2 = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd27);
    for (int k = 0; k < 5; k++) begin
      in_1 = 32'h40800000; in_2 = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("hold%0d_out", k), out, 32'h3EAAAAAB);
      check($sformatf("hold%0d_flags", k), {29'd0, dz, ovf, unf}, 32'd0);
      check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_valid", 32'(out_valid), 32'd0);
    run_and_check("after_hold", 32'h40400000, 32'h3F800000);

    // Reset while dividing.
    wait_ready();
    in_1 = 32'h3F800000; in_2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out", out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_partial", 32'(out_valid), 32'd0);
    run_and_check("after_rst", 32'h40800000, 32'h40000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
